multicycle_control_unit: RTL

- Next-generation RV32I control block: replaces the single-cycle opcode decoder with an FSM that steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK.
- Drives datapath enables and selects for the multi-cycle core.
- Handshakes with instruction and data memories via req/ready, with a programmable stall watchdog.
- Traps on illegal opcodes and on memory timeouts; counts retired instructions.

---
 rtl/multicycle_control_unit.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Multi-cycle RV32I control FSM. Steps each instruction through
//               FETCH, DECODE, EXEC, MEM and WB, drives datapath enables and
//               selects, handshakes with instruction/data memory via req/ready
//               under a stall watchdog, traps on illegal opcodes or memory
//               timeouts, and counts retired instructions.
// Ports       : clk, rst                    - clock, async active-high reset
//               opcode, branch_taken        - IR opcode, ALU branch result
//               imem_ready, dmem_ready      - memory acknowledges
//               imem_req, dmem_req, dmem_we - memory requests
//               ir_write, pc_write, pc_src  - fetch / PC control
//               alu_src, alu_op, mem_to_reg - datapath selects
//               reg_write, retire           - writeback enable, retire pulse
//               retired_count               - wrapping retire counter
//               trap, trap_cause            - sticky halt and its reason
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16,  // 0 disables the watchdog
  parameter int TO_WIDTH    = 8,   // MEM_TIMEOUT must fit in TO_WIDTH bits
  parameter int RET_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic [1:0]           alu_src,
  output logic [1:0]           alu_op,
  output logic [2:0]           mem_to_reg,
  output logic                 reg_write,
  output logic                 retire,
  output logic [RET_WIDTH-1:0] retired_count,
  output logic                 trap,
  output logic [1:0]           trap_cause
);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    OP_R       = 4'd0,
    OP_I       = 4'd1,
    OP_LOAD    = 4'd2,
    OP_STORE   = 4'd3,
    OP_BRANCH  = 4'd4,
    OP_JAL     = 4'd5,
    OP_JALR    = 4'd6,
    OP_LUI     = 4'd7,
    OP_AUIPC   = 4'd8,
    OP_ILLEGAL = 4'd9
  } op_t;

  localparam logic [1:0] C_CAUSE_ILLEGAL = 2'b00;
  localparam logic [1:0] C_CAUSE_IMEM    = 2'b01;
  localparam logic [1:0] C_CAUSE_DMEM    = 2'b10;
  // Count value seen on the last permitted wait cycle.
  localparam logic [TO_WIDTH-1:0] C_TO_LAST = TO_WIDTH'(MEM_TIMEOUT - 1);

  state_t                state_q, state_d;
  op_t                   op_q, op_d;
  op_t                   op_dec;
  logic [TO_WIDTH-1:0]   wd_cnt_q, wd_cnt_d;
  logic [1:0]            cause_q, cause_d;
  logic [RET_WIDTH-1:0]  ret_cnt_q, ret_cnt_d;
  logic                  waiting;
  logic                  timeout;
  logic [1:0]            sel_alu_src;
  logic [1:0]            sel_alu_op;
  logic [2:0]            sel_wb;

  // Opcode to op class.
  always_comb begin
    case (opcode)
      7'd51:   op_dec = OP_R;
      7'd19:   op_dec = OP_I;
      7'd3:    op_dec = OP_LOAD;
      7'd35:   op_dec = OP_STORE;
      7'd99:   op_dec = OP_BRANCH;
      7'd111:  op_dec = OP_JAL;
      7'd103:  op_dec = OP_JALR;
      7'd55:   op_dec = OP_LUI;
      7'd23:   op_dec = OP_AUIPC;
      default: op_dec = OP_ILLEGAL;
    endcase
  end

  // Datapath selects for the latched op class.
  always_comb begin
    sel_alu_src = 2'b00;
    sel_alu_op  = 2'b00;
    sel_wb      = 3'b000;
    case (op_q)
      OP_R:      sel_alu_op = 2'b11;
      OP_I:      begin sel_alu_src = 2'b01; sel_alu_op = 2'b10; end
      OP_LOAD:   begin sel_alu_src = 2'b01; sel_wb = 3'b001; end
      OP_STORE:  sel_alu_src = 2'b10;
      OP_BRANCH: sel_alu_op = 2'b01;
      OP_JAL:    sel_wb = 3'b010;
      OP_JALR:   begin sel_alu_src = 2'b01; sel_wb = 3'b010; end
      OP_LUI:    sel_wb = 3'b011;
      OP_AUIPC:  sel_wb = 3'b100;
      default:   sel_wb = 3'b000;
    endcase
  end

  // A request is outstanding and not yet acknowledged this cycle.
  assign waiting = ((state_q == ST_FETCH) && !imem_ready) ||
                   ((state_q == ST_MEM)   && !dmem_ready);
  // Fires on the MEM_TIMEOUT-th consecutive wait cycle; a same-cycle ready
  // clears waiting, so ready always wins.
  assign timeout = (MEM_TIMEOUT != 0) && waiting && (wd_cnt_q == C_TO_LAST);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cause_d    = cause_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src    = 2'b00;
    alu_op     = 2'b00;
    mem_to_reg = 3'b000;
    reg_write  = 1'b0;
    retire     = 1'b0;
    trap       = 1'b0;

    // Selects are held stable for the whole back half of the instruction.
    if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
      alu_src    = sel_alu_src;
      alu_op     = sel_alu_op;
      mem_to_reg = sel_wb;
    end

    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_TRAP;
          cause_d = C_CAUSE_IMEM;
        end
      end
      ST_DECODE: begin
        op_d = op_dec;
        if (op_dec == OP_ILLEGAL) begin
          state_d = ST_TRAP;
          cause_d = C_CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_BRANCH: begin
            pc_write = 1'b1;
            pc_src   = branch_taken ? 2'b01 : 2'b00;
            retire   = 1'b1;
            state_d  = ST_FETCH;
          end
          OP_LOAD, OP_STORE: state_d = ST_MEM;
          default:           state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_STORE);
        if (dmem_ready) begin
          if (op_q == OP_STORE) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout) begin
          state_d = ST_TRAP;
          cause_d = C_CAUSE_DMEM;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        if (op_q == OP_JAL)       pc_src = 2'b10;
        else if (op_q == OP_JALR) pc_src = 2'b11;
        state_d = ST_FETCH;
      end
      ST_TRAP: trap = 1'b1;
      default: state_d = ST_RST;
    endcase

    // Watchdog restarts on every state change, so each FETCH/MEM visit
    // starts from zero.
    if (state_d != state_q)
      wd_cnt_d = '0;
    else if (waiting)
      wd_cnt_d = wd_cnt_q + 1'b1;
    else
      wd_cnt_d = wd_cnt_q;

    ret_cnt_d = ret_cnt_q + {{(RET_WIDTH-1){1'b0}}, retire};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RST;
      op_q      <= OP_R;
      wd_cnt_q  <= '0;
      cause_q   <= C_CAUSE_ILLEGAL;
      ret_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wd_cnt_q  <= wd_cnt_d;
      cause_q   <= cause_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign retired_count = ret_cnt_q;
  // cause_q only changes on entry to TRAP, so it reads 00 everywhere else.
  assign trap_cause    = cause_q;

endmodule
`default_nettype wire
